bus_slave_port: RTL
===================

// Module: bus_slave_port
// PURPOSE
// - Slave-side serial bus endpoint; directly downstream of the master's serial bus driver.
// - Deserialises the master frame (16-bit address, RW bit, optional 8-bit write data); acknowledges when the address selects this slave.
// - Issues single-cycle writes/reads to a local 8-bit memory; serialises read data back onto the bus.
// PARAMETERS
// - SLAVE_ID   4'h1  address bits [15:12] that select this slave
// - LOC_AW     12    local address width (= address bits [11:0])
// - RD_TIMEOUT 15    max cycles to wait for S_RVALID before error
// PORTS
// - CLK        in   1       system clock, rising edge
// - RST        in   1       synchronous reset, active-high
// - B_VALID    in   1       master frame valid; high for the whole frame
// - B_BUS_IN   in   1       serial data from master, LSB first
// - B_ACK      out  1       slave acknowledge (1-cycle pulse)
// - B_SBSY     out  1       slave busy, ACK through end of transaction
// - B_BUS_OUT  out  1       serial read data to master, LSB first
// - B_BUS_OE   out  1       B_BUS_OUT valid / drive enable
// - B_ERR      out  1       1-cycle pulse: read timeout
// - S_ADDR     out  LOC_AW  local address
// - S_DOUT     out  8       local write data
// - S_WEN      out  1       local write strobe (1 cycle)
// - S_REN      out  1       local read request (1 cycle)
// - S_DIN      in   8       local read data
// - S_RVALID   in   1       S_DIN valid (any latency >=1)
// BEHAVIOUR
// - Reset: every output 0; state IDLE; shift regs and counters 0. RST mid-frame abandons the frame with no S_WEN/S_REN.
// - IDLE: B_VALID=1 samples address bit 0 this cycle -> ADDR.
// - ADDR: 16 bits total (bits 0..15, one per cycle) -> RW, sampled on the next cycle (1=write).
// - Decode at the RW cycle. If addr[15:12]==SLAVE_ID -> ACK, else DROP.
// - ACK: B_ACK=1 and B_SBSY=1 for 1 cycle, exactly 1 cycle after the RW bit. Write -> WDATA; read -> RREQ.
// - WDATA: 8 cycles of B_BUS_IN, LSB first -> WRITE.
// - WRITE: S_WEN=1 for 1 cycle, with S_ADDR=addr[11:0] and S_DOUT=data -> IDLE.
// - RREQ: S_REN=1 for 1 cycle -> RWAIT.
// - RWAIT: S_RVALID latches S_DIN -> RDATA.
//   - If RD_TIMEOUT cycles pass without S_RVALID: B_ERR pulse -> IDLE.
//   - S_RVALID on the same cycle as the timeout: data wins.
// - RDATA: B_BUS_OE=1 for 8 cycles, B_BUS_OUT=bit i on cycle i -> IDLE.
// - DROP: no outputs; stay until B_VALID=0 -> IDLE.
// - B_VALID=0 in ADDR/RW/WDATA: abort to IDLE next cycle; no strobes, no ACK.
// - B_VALID is ignored in ACK, RREQ, RWAIT and RDATA.
// - B_SBSY=1 from ACK until the cycle before return to IDLE; covers RWAIT and RDATA.
// - Back-to-back frames: a new frame may start the cycle after IDLE is re-entered.
// - Bit counter 4 bits, wraps 15->0 at ADDR exit; reused for WDATA and RDATA (0..7).
// - S_RVALID outside RWAIT is ignored.
// STRUCTURE
// - Shared package bus_pkg:
//   - typedef enum slv_state_e {IDLE, ADDR, RW, ACK, WDATA, WRITE, RREQ, RWAIT, RDATA, DROP}
//   - localparams ADDR_BITS=16, DATA_BITS=8, ID_MSB=15, ID_LSB=12
// - One sub-module: serial_shift_reg, LSB-first shift-in/shift-out, width param, load/shift enables; instanced for address (16) and data (8).
// - FSM, counters and decode stay in bus_slave_port.
// TESTING
// - Write hit: addr 16'h1A5C, RW=1, data 8'hAD.
//   -> B_ACK 1 cycle after the RW bit.
//   -> S_WEN 1 cycle, 8 cycles later; S_ADDR=12'hA5C, S_DOUT=8'hAD.
//   -> B_SBSY high ACK..WRITE.
// - Read hit: addr 16'h1003, RW=0; S_DIN=8'h5B with S_RVALID 3 cycles after S_REN.
//   -> B_BUS_OE 8 cycles; B_BUS_OUT = 1,1,0,1,1,0,1,0.
// - Address miss: addr 16'h2A5C.
//   -> no B_ACK, S_WEN, S_REN or B_SBSY; returns to IDLE after B_VALID falls.
// - Abort: B_VALID drops after 4 write-data bits.
//   -> IDLE next cycle; S_WEN never asserted.
//   -> a following frame to 16'h1001 is accepted normally.
// - Read timeout: S_RVALID held 0.
//   -> B_ERR pulse RD_TIMEOUT=15 cycles after S_REN; B_BUS_OE never asserted.
// - Reset: RST=1 during RWAIT.
//   -> all outputs 0 next cycle; state IDLE; a late S_RVALID is ignored.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the serial slave bus endpoint.
package bus_pkg;

   typedef enum logic [3:0] {
      IDLE, ADDR, RW, ACK, WDATA, WRITE, RREQ, RWAIT, RDATA, DROP
   } slv_state_e;

   localparam int unsigned ADDR_BITS = 16;
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned ID_MSB    = 15;
   localparam int unsigned ID_LSB    = 12;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB and move toward bit 0,
// so par_o[0] is both the first bit received and the next bit to send.
module serial_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= load_data_i;
      end else if (shift_i) begin
         data_q <= {ser_i, data_q[WIDTH-1:1]};
      end
   end

   assign par_o = data_q;

endmodule

// File: rtl/bus_slave_port.sv
// Slave endpoint: deserialises address/RW/write data, strobes the local memory,
// and serialises read data back to the master.
module bus_slave_port
   import bus_pkg::*;
#(
   parameter logic [3:0]  SLAVE_ID   = 4'h1,
   parameter int unsigned LOC_AW     = 12,
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              B_VALID,
   input  logic              B_BUS_IN,
   output logic              B_ACK,
   output logic              B_SBSY,
   output logic              B_BUS_OUT,
   output logic              B_BUS_OE,
   output logic              B_ERR,
   output logic [LOC_AW-1:0] S_ADDR,
   output logic [7:0]        S_DOUT,
   output logic              S_WEN,
   output logic              S_REN,
   input  logic [7:0]        S_DIN,
   input  logic              S_RVALID
);

   localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

   slv_state_e state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] wait_q, wait_d;
   logic          rw_q, rw_d;

   logic                 addr_shift, data_shift, data_load;
   logic [ADDR_BITS-1:0] addr_par;
   logic [DATA_BITS-1:0] data_par;
   logic                 hit, timeout;

   assign hit     = (addr_par[ID_MSB:ID_LSB] == SLAVE_ID);
   assign timeout = (wait_q == TW'(RD_TIMEOUT - 1));

   serial_shift_reg #(.WIDTH(ADDR_BITS)) u_addr_sr (
      .clk_i       (CLK),
      .rst_i       (RST),
      .load_i      (1'b0),
      .load_data_i ('0),
      .shift_i     (addr_shift),
      .ser_i       (B_BUS_IN),
      .par_o       (addr_par)
   );

   // Shared for write data (shift in) and read data (load, then shift out).
   serial_shift_reg #(.WIDTH(DATA_BITS)) u_data_sr (
      .clk_i       (CLK),
      .rst_i       (RST),
      .load_i      (data_load),
      .load_data_i (S_DIN),
      .shift_i     (data_shift),
      .ser_i       (B_BUS_IN),
      .par_o       (data_par)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wait_d     = wait_q;
      rw_d       = rw_q;
      addr_shift = 1'b0;
      data_shift = 1'b0;
      data_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (B_VALID) begin
               addr_shift = 1'b1;
               cnt_d      = 4'd1;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (!B_VALID) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               addr_shift = 1'b1;
               cnt_d      = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = RW;
            end
         end
         RW: begin
            if (!B_VALID) begin
               state_d = IDLE;
            end else begin
               rw_d    = B_BUS_IN;
               state_d = hit ? ACK : DROP;
            end
         end
         ACK: begin
            cnt_d   = '0;
            state_d = rw_q ? WDATA : RREQ;
         end
         WDATA: begin
            if (!B_VALID) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               data_shift = 1'b1;
               cnt_d      = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d   = '0;
                  state_d = WRITE;
               end
            end
         end
         WRITE: state_d = IDLE;
         RREQ: begin
            wait_d  = '0;
            state_d = RWAIT;
         end
         RWAIT: begin
            // Data arriving on the timeout cycle takes priority over the error.
            if (S_RVALID) begin
               data_load = 1'b1;
               cnt_d     = '0;
               state_d   = RDATA;
            end else if (timeout) begin
               state_d = IDLE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         RDATA: begin
            data_shift = 1'b1;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (!B_VALID) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      B_ACK     = 1'b0;
      B_SBSY    = 1'b0;
      B_BUS_OUT = 1'b0;
      B_BUS_OE  = 1'b0;
      B_ERR     = 1'b0;
      S_ADDR    = '0;
      S_DOUT    = '0;
      S_WEN     = 1'b0;
      S_REN     = 1'b0;
      case (state_q)
         ACK: begin
            B_ACK  = 1'b1;
            B_SBSY = 1'b1;
         end
         WDATA: B_SBSY = 1'b1;
         WRITE: begin
            B_SBSY = 1'b1;
            S_WEN  = 1'b1;
            S_ADDR = addr_par[LOC_AW-1:0];
            S_DOUT = data_par;
         end
         RREQ: begin
            B_SBSY = 1'b1;
            S_REN  = 1'b1;
            S_ADDR = addr_par[LOC_AW-1:0];
         end
         RWAIT: begin
            B_SBSY = 1'b1;
            B_ERR  = timeout && !S_RVALID;
         end
         RDATA: begin
            B_SBSY    = 1'b1;
            B_BUS_OE  = 1'b1;
            B_BUS_OUT = data_par[0];
         end
         default: ;
      endcase
   end

endmodule
